pkt_tx_framer: RTL and testbench

- Transmit-side packet framer; it is the counterpart to the vid/data packet receiver.
- Accepts a start command (header type, payload length) and a stream of 16-bit payload words over a valid/ready handshake.
- Emits a contiguous vid_out/data_out frame: header word, payload words, then a ones-complement checksum word, followed by a mandatory idle gap.
- Sits between the payload source (FIFO/DMA) and the PPU input link.

---
 rtl/pkt_tx_framer.sv | 195 +++++++++++++++++++
 tb/tb_pkt_tx_framer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer: transmit framer emitting header, payload and ones-complement checksum.
// Optional macro CHK_ERR_INJ_EN adds err_inj to corrupt the checksum for receiver tests.
module pkt_tx_framer #(
    parameter int          MAX_LEN  = 599,
    parameter int          IFG      = 4,
    parameter logic [15:0] HDR_DATA = 16'h55D5,
    parameter logic [15:0] HDR_CTRL = 16'h55D4
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        start,
    input  logic        hdr_type,
    input  logic [9:0]  len,
    output logic        busy,
    input  logic        pl_valid,
    input  logic [15:0] pl_data,
    output logic        pl_ready,
    output logic        vid_out,
    output logic [15:0] data_out,
    output logic        err_len,
    output logic        err_underrun
`ifdef CHK_ERR_INJ_EN
    ,
    input  logic        err_inj
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PAY,
        CHK,
        GAP
    } state_t;

    localparam int          GW       = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'(IFG - 1);
    localparam logic [9:0]  MAX_L    = 10'(MAX_LEN);

    state_t        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [16:0]   acc_q, acc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   data_q, data_d;
    logic          vid_q, vid_d;
    logic          busy_q, busy_d;
    logic          el_q, el_d;
    logic          eu_q, eu_d;

    logic          len_ok;
    logic [16:0]   acc_sum;
    logic [15:0]   fold;
    logic [15:0]   chk;
    logic [15:0]   chk_tx;
    logic [15:0]   hdr_word;

`ifdef CHK_ERR_INJ_EN
    logic          inj_q, inj_d;
`endif

    // Length legality, end-around accumulation and checksum folding
    always_comb begin
        len_ok   = (len != 10'd0) && (len <= MAX_L);
        acc_sum  = {1'b0, acc_q[15:0]} + {16'd0, acc_q[16]}
                 + {1'b0, pl_data};
        fold     = acc_q[15:0] + {15'd0, acc_q[16]};
        chk      = (fold == 16'hFFFF) ? 16'hFFFF : ~fold;
        hdr_word = hdr_type ? HDR_CTRL : HDR_DATA;
`ifdef CHK_ERR_INJ_EN
        chk_tx   = inj_q ? (chk + 16'd1) : chk;
`else
        chk_tx   = chk;
`endif
    end

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        gap_d   = gap_q;
        data_d  = data_q;
        vid_d   = vid_q;
        busy_d  = busy_q;
        el_d    = 1'b0;
        eu_d    = 1'b0;
`ifdef CHK_ERR_INJ_EN
        inj_d   = inj_q;
`endif
        unique case (state_q)
            IDLE: begin
                vid_d  = 1'b0;
                data_d = 16'd0;
                busy_d = 1'b0;
                if (start) begin
                    if (len_ok) begin
                        data_d  = hdr_word;
                        vid_d   = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = len;
                        acc_d   = 17'd0;
`ifdef CHK_ERR_INJ_EN
                        inj_d   = err_inj;
`endif
                        state_d = PAY;
                    end else begin
                        // a held bad start still yields isolated pulses
                        el_d = ~el_q;
                    end
                end
            end
            PAY: begin
                if (pl_valid) begin
                    data_d = pl_data;
                    acc_d  = acc_sum;
                    cnt_d  = cnt_q - 10'd1;
                    if (cnt_q == 10'd1) begin
                        state_d = CHK;
                    end
                end else begin
                    // underrun: truncate, no checksum
                    vid_d   = 1'b0;
                    data_d  = 16'd0;
                    eu_d    = 1'b1;
                    gap_d   = GAP_INIT;
                    state_d = GAP;
                end
            end
            CHK: begin
                data_d  = chk_tx;
                gap_d   = GAP_INIT;
                state_d = GAP;
            end
            GAP: begin
                vid_d  = 1'b0;
                data_d = 16'd0;
                if (gap_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 10'd0;
            acc_q   <= 17'd0;
            gap_q   <= '0;
            data_q  <= 16'd0;
            vid_q   <= 1'b0;
            busy_q  <= 1'b0;
            el_q    <= 1'b0;
            eu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            vid_q   <= vid_d;
            busy_q  <= busy_d;
            el_q    <= el_d;
            eu_q    <= eu_d;
        end
    end

`ifdef CHK_ERR_INJ_EN
    // Checksum corruption flag held for the frame
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`endif

    // Output drive; pl_ready is the only combinational output
    always_comb begin
        pl_ready     = (state_q == PAY);
        vid_out      = vid_q;
        data_out     = data_q;
        busy         = busy_q;
        err_len      = el_q;
        err_underrun = eu_q;
    end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// tb_pkt_tx_framer: randomized self-checking bench for pkt_tx_framer.
// Frames are captured by a monitor and compared with a queue-based model.
module tb_pkt_tx_framer;

    localparam int          IFG      = 4;
    localparam int          MAX_LEN  = 599;
    localparam logic [15:0] HDR_DATA = 16'h55D5;
    localparam logic [15:0] HDR_CTRL = 16'h55D4;

    logic        clk_100m = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hdr_type = 1'b0;
    logic [9:0]  len = 10'd0;
    logic        pl_valid = 1'b0;
    logic [15:0] pl_data = 16'd0;
    logic        busy;
    logic        pl_ready;
    logic        vid_out;
    logic [15:0] data_out;
    logic        err_len;
    logic        err_underrun;
`ifdef CHK_ERR_INJ_EN
    logic        err_inj = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] mon_words[$];
    int          mon_len[$];
    int          mon_start[$];
    int          cur_len = 0;
    bit          in_frame = 0;
    int          n_el = 0;
    int          n_eu = 0;
    int          long_pulse = 0;
    int          idle_bad = 0;
    bit          prev_el = 0;
    bit          prev_eu = 0;

    pkt_tx_framer #(
        .MAX_LEN (MAX_LEN),
        .IFG     (IFG),
        .HDR_DATA(HDR_DATA),
        .HDR_CTRL(HDR_CTRL)
    ) dut (
        .clk_100m    (clk_100m),
        .rst         (rst),
        .start       (start),
        .hdr_type    (hdr_type),
        .len         (len),
        .busy        (busy),
        .pl_valid    (pl_valid),
        .pl_data     (pl_data),
        .pl_ready    (pl_ready),
        .vid_out     (vid_out),
        .data_out    (data_out),
        .err_len     (err_len),
        .err_underrun(err_underrun)
`ifdef CHK_ERR_INJ_EN
        ,
        .err_inj     (err_inj)
`endif
    );

    always #5 clk_100m = ~clk_100m;

    always @(posedge clk_100m) cyc <= cyc + 1;

    // frame capture and pulse-width watch
    always @(negedge clk_100m) begin
        if (vid_out) begin
            if (!in_frame) begin
                in_frame = 1;
                cur_len = 0;
                mon_start.push_back(cyc);
            end
            mon_words.push_back(data_out);
            cur_len++;
        end else begin
            if (in_frame) begin
                mon_len.push_back(cur_len);
                in_frame = 0;
            end
            if (data_out !== 16'd0) idle_bad++;
        end
        if (err_len) n_el++;
        if (err_underrun) n_eu++;
        if (err_len && prev_el) long_pulse++;
        if (err_underrun && prev_eu) long_pulse++;
        prev_el = err_len;
        prev_eu = err_underrun;
    end

    function automatic logic [15:0] ref_chk(input logic [15:0] w[$],
                                            input bit inj);
        int unsigned s;
        logic [15:0] f;
        logic [15:0] c;
        s = 0;
        foreach (w[i]) s += w[i];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        f = s[15:0];
        c = (f == 16'hFFFF) ? 16'hFFFF : ~f;
        if (inj) c = c + 16'd1;
        return c;
    endfunction

    task automatic clear_mon();
        mon_words.delete();
        mon_len.delete();
        mon_start.delete();
        n_el = 0;
        n_eu = 0;
    endtask

    // one frame; drop < L starves the framer after drop words
    task automatic run_frame(input bit h, input int L, input int drop,
                             input bit inj, input logic [15:0] dir[$],
                             input string nm);
        logic [15:0] sent[$];
        logic [15:0] exp_q[$];
        int t_acc, t_idle, nw, n;
        clear_mon();
        start = 1'b1;
        hdr_type = h;
        len = L[9:0];
`ifdef CHK_ERR_INJ_EN
        err_inj = inj;
`endif
        t_acc = cyc + 1;
        @(negedge clk_100m);
        start = 1'b0;
        hdr_type = 1'($urandom);
        len = 10'($urandom);
        nw = 0;
        t_idle = -1;
        for (int k = 0; k < 3000; k++) begin
            if (!busy) begin
                t_idle = cyc;
                break;
            end
            if (pl_ready && nw < drop) begin
                pl_valid = 1'b1;
                pl_data = (nw < dir.size()) ? dir[nw] : 16'($urandom);
                sent.push_back(pl_data);
                nw++;
            end else begin
                pl_valid = 1'b0;
                pl_data = 16'($urandom);
            end
            @(negedge clk_100m);
        end
        pl_valid = 1'b0;
        @(negedge clk_100m);
        n = (drop < L) ? drop : L;
        exp_q.push_back(h ? HDR_CTRL : HDR_DATA);
        foreach (sent[i]) exp_q.push_back(sent[i]);
        if (drop >= L) exp_q.push_back(ref_chk(sent, inj));
        n_cmp++;
        if (t_idle < 0) begin
            n_bad++;
            $display("FAIL %s busy_timeout: busy still 1 after 3000 cycles", nm);
        end else if (t_idle !== t_acc + n + 1 + IFG) begin
            n_bad++;
            $display("FAIL %s busy_drop: cycle %0d, want %0d",
                     nm, t_idle - t_acc, n + 1 + IFG);
        end
        n_cmp++;
        if (mon_len.size() !== 1) begin
            n_bad++;
            $display("FAIL %s frame_count: got %0d, want 1", nm, mon_len.size());
        end else begin
            n_cmp++;
            if (mon_start[0] !== t_acc) begin
                n_bad++;
                $display("FAIL %s hdr_time: got %0d, want %0d",
                         nm, mon_start[0], t_acc);
            end
            n_cmp++;
            if (mon_len[0] !== exp_q.size()) begin
                n_bad++;
                $display("FAIL %s frame_len: got %0d, want %0d",
                         nm, mon_len[0], exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_cmp++;
                    if (mon_words[i] !== exp_q[i]) begin
                        n_bad++;
                        $display("FAIL %s word%0d: got %h, want %h",
                                 nm, i, mon_words[i], exp_q[i]);
                    end
                end
            end
        end
        n_cmp++;
        if (n_eu !== ((drop < L) ? 1 : 0) || n_el !== 0) begin
            n_bad++;
            $display("FAIL %s err_pulses: underrun %0d len %0d, want %0d 0",
                     nm, n_eu, n_el, (drop < L) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_100m);
        n_cmp++;
        if ({vid_out, busy, pl_ready, err_len, err_underrun} !== 5'b0 ||
            data_out !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: vid%b busy%b rdy%b el%b eu%b data%h, want all 0",
                     vid_out, busy, pl_ready, err_len, err_underrun, data_out);
        end
        rst = 1'b0;
        @(negedge clk_100m);
        n_cmp++;
        if (busy !== 1'b0 || vid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: busy %b vid %b, want 0 0", busy, vid_out);
        end
    endtask

    task automatic test_directed();
        logic [15:0] d[$];
        d = '{16'h0001, 16'h0002, 16'h0003};
        run_frame(1'b0, 3, 3, 1'b0, d, "basic");
        d = '{16'hFFFF, 16'h0001};
        run_frame(1'b1, 2, 2, 1'b0, d, "carry");
        d = '{16'h0000};
        run_frame(1'b0, 1, 1, 1'b0, d, "fold_zero");
        d = '{16'hFFFF};
        run_frame(1'b1, 1, 1, 1'b0, d, "fold_ones");
`ifdef CHK_ERR_INJ_EN
        d = '{16'h0001, 16'h0002, 16'h0003};
        run_frame(1'b0, 3, 3, 1'b1, d, "err_inj");
`endif
    endtask

    task automatic test_len_err();
        logic [15:0] d[$];
        int bad_l[3];
        bit saw;
        bad_l = '{0, 622, MAX_LEN + 1};
        foreach (bad_l[j]) begin
            clear_mon();
            start = 1'b1;
            len = bad_l[j][9:0];
            hdr_type = 1'($urandom);
            @(negedge clk_100m);
            start = 1'b0;
            saw = 0;
            repeat (4) begin
                if (busy || vid_out) saw = 1;
                @(negedge clk_100m);
            end
            n_cmp++;
            if (n_el !== 1 || saw !== 0 || mon_len.size() !== 0) begin
                n_bad++;
                $display("FAIL len_err%0d: pulses %0d busy_or_vid %0d frames %0d, want 1 0 0",
                         bad_l[j], n_el, saw, mon_len.size());
            end
        end
        run_frame(1'($urandom), MAX_LEN, MAX_LEN, 1'b0, d, "max_len");
        run_frame(1'($urandom), 7, 7, 1'b0, d, "rand7");
    endtask

    task automatic test_underrun();
        logic [15:0] d[$];
        run_frame(1'b0, 10, 4, 1'b0, d, "underrun");
        run_frame(1'b1, 3, 3, 1'b0, d, "after_underrun");
    endtask

    task automatic test_back_to_back();
        localparam int L = 5;
        logic [15:0] sent[$];
        logic [15:0] seg[$];
        int t0;
        bit done;
        clear_mon();
        done = 0;
        start = 1'b1;
        hdr_type = 1'b1;
        len = 10'(L);
        t0 = cyc + 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_100m);
            start = (i < 24);
            if (i >= 24 && !busy) begin
                done = 1;
                break;
            end
            if (pl_ready) begin
                pl_valid = 1'b1;
                pl_data = 16'($urandom);
                sent.push_back(pl_data);
            end else begin
                pl_valid = 1'b0;
            end
        end
        start = 1'b0;
        pl_valid = 1'b0;
        @(negedge clk_100m);
        n_cmp++;
        if (!done || mon_len.size() !== 3 || sent.size() !== 3 * L) begin
            n_bad++;
            $display("FAIL b2b_frames: done %0d frames %0d words %0d, want 1 3 %0d",
                     done, mon_len.size(), sent.size(), 3 * L);
        end else begin
            for (int f = 0; f < 3; f++) begin
                n_cmp++;
                if (mon_start[f] !== t0 + f * (L + 2 + IFG) ||
                    mon_len[f] !== L + 2) begin
                    n_bad++;
                    $display("FAIL b2b_timing%0d: start %0d len %0d, want %0d %0d",
                             f, mon_start[f] - t0, mon_len[f],
                             f * (L + 2 + IFG), L + 2);
                end
                if (f > 0) begin
                    n_cmp++;
                    if (mon_start[f] - (mon_start[f-1] + mon_len[f-1]) !== IFG) begin
                        n_bad++;
                        $display("FAIL b2b_gap%0d: got %0d, want %0d", f,
                                 mon_start[f] - (mon_start[f-1] + mon_len[f-1]), IFG);
                    end
                end
                seg.delete();
                for (int k = 0; k < L; k++) seg.push_back(sent[f * L + k]);
                n_cmp++;
                if (mon_words[f * (L + 2)] !== HDR_CTRL ||
                    mon_words[f * (L + 2) + L + 1] !== ref_chk(seg, 1'b0)) begin
                    n_bad++;
                    $display("FAIL b2b_hdr_chk%0d: got %h %h, want %h %h", f,
                             mon_words[f * (L + 2)],
                             mon_words[f * (L + 2) + L + 1],
                             HDR_CTRL, ref_chk(seg, 1'b0));
                end
                for (int k = 0; k < L; k++) begin
                    n_cmp++;
                    if (mon_words[f * (L + 2) + 1 + k] !== seg[k]) begin
                        n_bad++;
                        $display("FAIL b2b_word%0d_%0d: got %h, want %h", f, k,
                                 mon_words[f * (L + 2) + 1 + k], seg[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d[$];
        clear_mon();
        start = 1'b1;
        hdr_type = 1'b0;
        len = 10'd8;
        @(negedge clk_100m);
        start = 1'b0;
        repeat (3) begin
            pl_valid = 1'b1;
            pl_data = 16'($urandom);
            @(negedge clk_100m);
        end
        rst = 1'b1;
        @(negedge clk_100m);
        n_cmp++;
        if ({vid_out, busy, pl_ready, err_len, err_underrun} !== 5'b0 ||
            data_out !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset: vid%b busy%b rdy%b el%b eu%b data%h, want all 0",
                     vid_out, busy, pl_ready, err_len, err_underrun, data_out);
        end
        rst = 1'b0;
        pl_valid = 1'b0;
        @(negedge clk_100m);
        n_cmp++;
        if (mon_len.size() !== 1 || n_eu !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_trunc: frames %0d underrun %0d, want 1 0",
                     mon_len.size(), n_eu);
        end else begin
            n_cmp++;
            if (mon_len[0] !== 4) begin
                n_bad++;
                $display("FAIL mid_reset_len: got %0d, want 4", mon_len[0]);
            end
        end
        run_frame(1'b1, 4, 4, 1'b0, d, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_len_err();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (long_pulse !== 0) begin
            n_bad++;
            $display("FAIL pulse_width: %0d long pulses, want 0", long_pulse);
        end
        n_cmp++;
        if (idle_bad !== 0) begin
            n_bad++;
            $display("FAIL idle_data: %0d nonzero idle words, want 0", idle_bad);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
